// File: rtl/aes_out_pkg.sv
// Shared widths, FSM state type and word-select helper for the AES output serializer.
package aes_out_pkg;
  localparam int BLK_W         = 128;
  localparam int WORD_W        = 32;
  localparam int WORDS_PER_BLK = 4;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                  input logic [1:0]       idx);
    return blk[BLK_W-1-int'(idx)*WORD_W -: WORD_W];
  endfunction
endpackage

// File: rtl/aes_out_fifo.sv
// 128-bit synchronous FIFO with wrap-bit pointers; the caller must not push
// when full unless it pops in the same cycle.
module aes_out_fifo
  import aes_out_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [BLK_W-1:0]         din,
  input  logic                     pop,
  output logic [BLK_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [BLK_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
endmodule

// File: rtl/aes_out_serializer.sv
// Captures AES output blocks on a valid rise and streams them as 32-bit words, MSW first.
// Optional macro AES_OUT_PARITY_EN adds the word_parity output.
module aes_out_serializer
  import aes_out_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        AES_clk,
  input  logic                        AES_rst,
  input  logic                        blk_valid,
  input  logic [BLK_W-1:0]            blk_data,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [WORD_W-1:0]           word_data,
  output logic                        word_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
`ifdef AES_OUT_PARITY_EN
  output logic                        word_parity,
`endif
  output logic                        blk_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             r_prev_valid;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_idx;
  logic             w_rise;
  logic             w_hs;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [BLK_W-1:0] w_head;

  assign w_rise = blk_valid & ~r_prev_valid;
  assign w_hs   = word_valid & word_ready;
  assign w_pop  = w_hs & (r_idx == 2'd3);
  // A full FIFO still accepts a block when the head leaves on the same edge.
  assign w_push = w_rise & (~w_full | w_pop);

  aes_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (AES_clk),
    .rst   (AES_rst),
    .push  (w_push),
    .din   (blk_data),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Valid comes straight from FIFO occupancy so word 0 appears one cycle after capture.
  assign word_valid = ~w_empty;
  assign word_data  = word_valid ? blk_word(w_head, r_idx) : '0;
  assign word_last  = word_valid & (r_idx == 2'd3);

`ifdef AES_OUT_PARITY_EN
  assign word_parity = word_valid & (^word_data);
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (!w_empty) w_state_nxt = SEND;
      SEND: if (w_pop && !w_push && fifo_count == CW'(1)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or posedge AES_rst) begin
    if (AES_rst) begin
      r_prev_valid <= 1'b0;
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      blk_overflow <= 1'b0;
    end else begin
      r_prev_valid <= blk_valid;
      r_state      <= w_state_nxt;
      if (w_hs)                          r_idx        <= r_idx + 2'd1;
      if (w_rise && w_full && !w_pop)    blk_overflow <= 1'b1;
    end
  end
endmodule

// File: doc/aes_out_serializer.md
AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 2, number of buffered 128-bit blocks, power of two and at least 2.
REQ-002 The block SHALL have input AES_clk, 1 bit, the single clock; all logic SHALL be rising-edge.
REQ-003 The block SHALL have input AES_rst, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have input blk_valid, 1 bit, driven by the AES core's AES_data_out_valid.
REQ-005 The block SHALL have input blk_data, 128 bits, driven by the AES core's AES_data_out.
REQ-006 The block SHALL have output word_valid, 1 bit, meaning an output word is presented.
REQ-007 The block SHALL have input word_ready, 1 bit, meaning the consumer accepts word_data.
REQ-008 The block SHALL have output word_data, 32 bits, the current ciphertext word.
REQ-009 The block SHALL have output word_last, 1 bit, marking the fourth word of a block.
REQ-010 The block SHALL have output fifo_count, clog2(FIFO_DEPTH)+1 bits, the number of blocks stored.
REQ-011 The block SHALL have output blk_overflow, 1 bit, a sticky flag indicating a block was dropped.

Function
REQ-012 Capture SHALL occur only on a blk_valid rise (1 now, 0 in the previous cycle); a held-high valid captures once.
REQ-013 A captured blk_data SHALL be pushed into the FIFO in the same edge as the capture.
REQ-014 Word order SHALL be MSW first: word 0 = [127:96], word 1 = [95:64], word 2 = [63:32], word 3 = [31:0].
REQ-015 The serializer FSM SHALL have states IDLE and SEND.
REQ-016 IDLE SHALL go to SEND when the FIFO is non-empty.
REQ-017 SEND SHALL advance the 2-bit word index on each word_valid&&word_ready handshake.
REQ-018 On the word-3 handshake, SEND SHALL pop the FIFO head and reset the index to 0, then stay in SEND if the FIFO is still non-empty, else go to IDLE.
REQ-019 Latency SHALL be one cycle: a block captured at edge N into an empty FIFO gives word_valid=1 with word 0 after edge N.
REQ-020 While word_valid=1 and word_ready=0, word_data, word_last and the index SHALL hold stable.
REQ-021 word_valid SHALL NOT drop without a handshake.
REQ-022 word_last SHALL equal 1 exactly when word_valid=1 and the index is 3.
REQ-023 When the FIFO is full and a capture coincides with the word-3 handshake, push and pop SHALL both occur, the block SHALL be accepted, and fifo_count SHALL be unchanged.
REQ-024 When the FIFO is full and a capture occurs with no pop, the new block SHALL be dropped, blk_overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-025 blk_overflow SHALL clear only on reset.
REQ-026 Back-to-back blocks SHALL stream with no bubble between word 3 and the next word 0.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH, with an extra wrap bit to distinguish full from empty.

Reset
REQ-028 AES_rst=1 SHALL immediately force word_valid=0, word_data=0, word_last=0, fifo_count=0, blk_overflow=0, state IDLE, index 0, pointers 0, and the previous-valid register 0.
REQ-029 Reset asserted mid-block SHALL discard all partially sent and buffered blocks with no resumption.
REQ-030 After reset release, a blk_valid already high SHALL count as a rise.

Configuration
REQ-031 When macro AES_OUT_PARITY_EN is defined, the block SHALL add output word_parity, 1 bit, equal to the XOR of word_data[31:0] and valid with word_valid; it SHALL reset to 0.
REQ-032 When AES_OUT_PARITY_EN is undefined, the port and its logic SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-033 Package aes_out_pkg SHALL hold BLK_W=128, WORD_W=32, WORDS_PER_BLK=4 and the FSM state typedef {IDLE, SEND}.
REQ-034 Block storage SHALL be sub-module aes_out_fifo (128-bit synchronous FIFO with push, pop, full, empty and count).
REQ-035 The rise detector, FSM and word mux SHALL reside in aes_out_serializer.

Verification
REQ-036 Single block: blk_data=3925841d_02dc09fb_dc118597_196a0b32 and word_ready=1 SHALL give 3925841d, 02dc09fb, dc118597, 196a0b32 on consecutive cycles, word_last on the fourth, and word_valid rising one cycle after capture.
REQ-037 Backpressure: word_ready=0 for 5 cycles during word 1 SHALL hold word_data=02dc09fb, with all 4 words eventually delivered in order.
REQ-038 Held valid: blk_valid high for 20 cycles SHALL produce exactly one block (4 words), with fifo_count peaking at 1.
REQ-039 Overflow: with word_ready=0, three rises with FIFO_DEPTH=2 SHALL give fifo_count=2 and blk_overflow=1, and the output SHALL be the first two blocks only.
REQ-040 Full simultaneous: with FIFO full and a capture on the word-3 handshake, blk_overflow SHALL stay 0 and 3 blocks SHALL be delivered.
REQ-041 Reset mid-block: AES_rst asserted after word 1 SHALL immediately give word_valid=0 and fifo_count=0; a new block after release SHALL start at word 0.
